fx_chain: RTL and testbench

FX_CHAIN -- requirements
Module: fx_chain

---
 rtl/fx_chain.sv | 149 ++++++++++++++
 tb/tb_fx_chain.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/fx_chain.sv
// Four-stage audio effect chain: input gain, clip/shape, volume, with a
// single global stall and a saturating clip-event counter.
module fx_chain #(
  parameter int IN_W      = 12,
  parameter int FXP_W     = 16,
  parameter int GAIN_W    = 11,
  parameter int GAIN_FRAC = 4,
  parameter int VOL_W     = 8,
  parameter int THRESH    = 2047
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  output logic              i_ready,
  input  logic [IN_W-1:0]   i_sample,
  input  logic [GAIN_W-1:0] i_par_gain,
  input  logic [1:0]        i_par_mode,
  input  logic [VOL_W-1:0]  i_par_vol,
  input  logic              i_clip_clr,
  output logic              o_valid,
  input  logic              o_ready,
  output logic [FXP_W-1:0]  o_sample,
  output logic [15:0]       o_clip_cnt
);

  localparam int GP_W = FXP_W + GAIN_W + 1;
  localparam int VP_W = FXP_W + VOL_W + 1;
  localparam logic signed [GP_W-1:0] G_MAX = GP_W'({1'b0, {(FXP_W-1){1'b1}}});
  localparam logic signed [GP_W-1:0] G_MIN = ~G_MAX;
  localparam logic signed [VP_W-1:0] V_MAX = VP_W'({1'b0, {(FXP_W-1){1'b1}}});
  localparam logic signed [VP_W-1:0] V_MIN = ~V_MAX;
  localparam logic signed [FXP_W:0]  THR   = (FXP_W+1)'(THRESH);

  function automatic logic signed [FXP_W-1:0] apply_gain(
    input logic signed [FXP_W-1:0] x,
    input logic [GAIN_W-1:0]       g
  );
    logic signed [GP_W-1:0] prod;
    prod = GP_W'(x) * GP_W'($signed({1'b0, g}));
    prod = prod >>> GAIN_FRAC;
    if (prod > G_MAX)      return G_MAX[FXP_W-1:0];
    else if (prod < G_MIN) return G_MIN[FXP_W-1:0];
    else                   return prod[FXP_W-1:0];
  endfunction

  function automatic logic signed [FXP_W-1:0] apply_vol(
    input logic signed [FXP_W-1:0] x,
    input logic [VOL_W-1:0]        v
  );
    logic signed [VP_W-1:0] prod;
    prod = VP_W'(x) * VP_W'($signed({1'b0, v}));
    prod = prod >>> 7;
    if (prod > V_MAX)      return V_MAX[FXP_W-1:0];
    else if (prod < V_MIN) return V_MIN[FXP_W-1:0];
    else                   return prod[FXP_W-1:0];
  endfunction

  logic                     en;
  logic                     vld_p0, vld_p1, vld_p2, vld_p3;
  logic signed [FXP_W-1:0]  x_p0, x_p1, x_p2, x_p3;
  logic [GAIN_W-1:0]        gain_p0;
  logic [1:0]               mode_p0, mode_p1;
  logic [VOL_W-1:0]         vol_p0, vol_p1, vol_p2;
  logic                     clip_p2;
  logic [15:0]              clip_cnt;

  logic signed [FXP_W:0]    ext_p1, mag_p1, soft_p1;
  logic                     over_p1, clip_p1;
  logic signed [FXP_W-1:0]  shaped_p1;

  // One enable for the whole chain: a stalled output freezes every stage.
  assign en         = !vld_p3 || o_ready;
  assign i_ready    = en;
  assign o_valid    = vld_p3;
  assign o_sample   = x_p3;
  assign o_clip_cnt = clip_cnt;

  // Magnitude is one bit wider so the most negative sample folds correctly.
  always_comb begin
    ext_p1    = {x_p1[FXP_W-1], x_p1};
    mag_p1    = x_p1[FXP_W-1] ? -ext_p1 : ext_p1;
    over_p1   = mag_p1 > THR;
    soft_p1   = THR + ((mag_p1 - THR) >>> 2);
    shaped_p1 = x_p1;
    clip_p1   = 1'b0;
    case (mode_p1)
      2'b01: if (over_p1) begin
        shaped_p1 = FXP_W'(x_p1[FXP_W-1] ? -THR : THR);
        clip_p1   = 1'b1;
      end
      2'b10: if (over_p1) begin
        shaped_p1 = FXP_W'(x_p1[FXP_W-1] ? -soft_p1 : soft_p1);
        clip_p1   = 1'b1;
      end
      2'b11: shaped_p1 = '0;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0  <= 1'b0;
      vld_p1  <= 1'b0;
      vld_p2  <= 1'b0;
      vld_p3  <= 1'b0;
      x_p0    <= '0;
      x_p1    <= '0;
      x_p2    <= '0;
      x_p3    <= '0;
      gain_p0 <= '0;
      mode_p0 <= '0;
      mode_p1 <= '0;
      vol_p0  <= '0;
      vol_p1  <= '0;
      vol_p2  <= '0;
      clip_p2 <= 1'b0;
    end else if (en) begin
      // S0: capture sample and its parameter set together
      vld_p0  <= i_valid;
      x_p0    <= FXP_W'($signed(i_sample));
      gain_p0 <= i_par_gain;
      mode_p0 <= i_par_mode;
      vol_p0  <= i_par_vol;
      // S1: input gain
      vld_p1  <= vld_p0;
      x_p1    <= apply_gain(x_p0, gain_p0);
      mode_p1 <= mode_p0;
      vol_p1  <= vol_p0;
      // S2: clip / shape
      vld_p2  <= vld_p1;
      x_p2    <= shaped_p1;
      vol_p2  <= vol_p1;
      clip_p2 <= clip_p1 && vld_p1;
      // S3: output volume
      vld_p3  <= vld_p2;
      x_p3    <= apply_vol(x_p2, vol_p2);
    end
  end

  // A clip is counted as its sample leaves S2; clear beats a same-cycle event.
  always_ff @(posedge clk) begin
    if (rst || i_clip_clr) begin
      clip_cnt <= '0;
    end else if (en && vld_p2 && clip_p2 && clip_cnt != 16'hFFFF) begin
      clip_cnt <= clip_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_fx_chain.sv
// Randomized and directed bench for fx_chain with a queue-based reference model.
module tb_fx_chain;

  localparam int IN_W      = 12;
  localparam int FXP_W     = 16;
  localparam int GAIN_W    = 11;
  localparam int GAIN_FRAC = 4;
  localparam int VOL_W     = 8;
  localparam int THRESH    = 2047;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_valid;
  logic              i_ready;
  logic [IN_W-1:0]   i_sample;
  logic [GAIN_W-1:0] i_par_gain;
  logic [1:0]        i_par_mode;
  logic [VOL_W-1:0]  i_par_vol;
  logic              i_clip_clr;
  logic              o_valid;
  logic              o_ready;
  logic [FXP_W-1:0]  o_sample;
  logic [15:0]       o_clip_cnt;

  fx_chain #(
    .IN_W(IN_W), .FXP_W(FXP_W), .GAIN_W(GAIN_W), .GAIN_FRAC(GAIN_FRAC),
    .VOL_W(VOL_W), .THRESH(THRESH)
  ) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(i_ready),
    .i_sample(i_sample), .i_par_gain(i_par_gain), .i_par_mode(i_par_mode),
    .i_par_vol(i_par_vol), .i_clip_clr(i_clip_clr), .o_valid(o_valid),
    .o_ready(o_ready), .o_sample(o_sample), .o_clip_cnt(o_clip_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint y;
    bit     clip;
  } exp_t;

  exp_t   q[$];
  int     n_cmp = 0;
  int     n_bad = 0;
  longint mcnt = 0;
  bit     stall_prev = 0;
  longint prev_y = 0;
  bit     clr_drive = 0;
  bit     clr_last = 0;
  bit     last_acc = 0;
  int     pops = 0;
  int     stalls = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint sat_fxp(input longint v);
    longint hi = (longint'(1) <<< (FXP_W-1)) - 1;
    if (v > hi)      return hi;
    if (v < -hi - 1) return -hi - 1;
    return v;
  endfunction

  // Straight arithmetic from the block's rules: gain, shape, volume.
  function automatic void ref_model(input longint s, input int g, input int m, input int v,
                                    output longint y, output bit clip);
    longint x, a, r, sg;
    x    = sat_fxp((s * g) >>> GAIN_FRAC);
    a    = (x < 0) ? -x : x;
    sg   = (x < 0) ? -1 : 1;
    clip = (m == 1 || m == 2) && (a > THRESH);
    case (m)
      1:       r = clip ? sg * THRESH : x;
      2:       r = clip ? sg * (THRESH + (a - THRESH) / 4) : x;
      3:       r = 0;
      default: r = x;
    endcase
    y = sat_fxp((r * v) >>> 7);
  endfunction

  task automatic step(input bit iv, input logic [IN_W-1:0] s, input logic [GAIN_W-1:0] g,
                      input logic [1:0] m, input logic [VOL_W-1:0] v, input bit rdy);
    exp_t e;
    i_valid = iv; i_sample = s; i_par_gain = g; i_par_mode = m; i_par_vol = v;
    o_ready = rdy; i_clip_clr = clr_drive;
    #1;
    if (clr_last) mcnt = 0;
    if (stall_prev) begin
      chk("hold_valid", o_valid, 1);
      chk("hold_sample", $signed(o_sample), prev_y);
    end
    if (o_valid && !rdy) begin
      chk("ready_low", i_ready, 0);
      stalls++;
    end
    if (o_valid && rdy) begin
      if (q.size() == 0) chk("stale_out", o_valid, 0);
      else begin
        e = q.pop_front();
        pops++;
        chk("sample", $signed(o_sample), e.y);
        if (e.clip && !clr_last && mcnt < 65535) mcnt++;
        chk("clip_cnt", o_clip_cnt, mcnt);
      end
    end
    stall_prev = o_valid && !rdy;
    prev_y     = $signed(o_sample);
    last_acc   = iv && i_ready;
    if (last_acc) begin
      ref_model(longint'($signed(s)), int'(g), int'(m), int'(v), e.y, e.clip);
      q.push_back(e);
    end
    clr_last = clr_drive;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, '0, '0, '0, '0, 1'b1);
  endtask

  task automatic directed(input string tag, input int s, input int g, input int m, input int v,
                          input longint exp_y, input longint exp_cnt);
    int lat;
    step(1'b1, IN_W'(s), GAIN_W'(g), 2'(m), VOL_W'(v), 1'b1);
    lat = 1;
    while (!o_valid && lat < 20) begin
      idle();
      lat++;
    end
    chk({tag, "_lat"}, lat, 4);
    chk({tag, "_y"}, $signed(o_sample), exp_y);
    chk({tag, "_cnt"}, o_clip_cnt, exp_cnt);
    idle();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int sent;
    int pops_base;
    int stalls_base;
    rst = 1'b1; i_valid = 1'b0; i_sample = '0; i_par_gain = '0; i_par_mode = '0;
    i_par_vol = '0; i_clip_clr = 1'b0; o_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", o_valid, 0);
    chk("rst_sample", o_sample, 0);
    chk("rst_cnt", o_clip_cnt, 0);
    chk("rst_ready", i_ready, 1);
    @(negedge clk);
    rst = 1'b0;

    directed("unity",    -2048,   16, 0, 128,  -2048, 0);
    directed("hard_pos",  1000,   64, 1, 128,   2047, 1);
    directed("hard_neg", -1000,   64, 1, 128,  -2047, 2);
    directed("soft_hi",   1000,   64, 2, 128,   2535, 3);
    directed("soft_lo",    511,   64, 2, 128,   2044, 3);
    directed("sat_pos",   2047, 2047, 0, 255,  32767, 3);
    directed("sat_neg",  -2048, 2047, 0, 255, -32768, 3);

    // Eight distinct samples, output stalled for three cycles mid-stream.
    sent = 0; pops_base = pops; stalls_base = stalls;
    for (int t = 0; t < 40 && (sent < 8 || q.size() > 0); t++) begin
      step(sent < 8, IN_W'(37 * sent - 120), GAIN_W'(16), 2'd0, VOL_W'(128),
           !(t >= 4 && t < 7));
      if (last_acc) sent++;
    end
    chk("bp_outputs", pops - pops_base, 8);
    chk("bp_stalls", stalls - stalls_base, 3);

    for (int t = 0; t < 600; t++) begin
      step($urandom_range(0, 3) != 0, IN_W'($urandom), GAIN_W'($urandom),
           2'($urandom_range(0, 3)), VOL_W'($urandom), $urandom_range(0, 3) != 0);
    end
    for (int k = 0; k < 60 && q.size() > 0; k++) idle();
    chk("drain_empty", q.size(), 0);

    // Reset with three samples in flight and a nonzero counter.
    for (int k = 0; k < 3; k++) step(1'b1, IN_W'(500 + k), GAIN_W'(64), 2'd1, VOL_W'(128), 1'b1);
    rst = 1'b1; i_valid = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_valid", o_valid, 0);
    chk("midrst_sample", o_sample, 0);
    chk("midrst_cnt", o_clip_cnt, 0);
    chk("midrst_ready", i_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    q.delete(); mcnt = 0; stall_prev = 0; clr_last = 0;
    repeat (10) idle();
    chk("post_rst_idle", o_valid, 0);

    directed("clip_a", 1000, 64, 1, 128, 2047, 1);
    clr_drive = 1'b1;
    directed("clip_clr", 1000, 64, 1, 128, 2047, 0);
    clr_drive = 1'b0;
    idle();
    chk("clr_after", o_clip_cnt, 0);
    directed("clip_b", -1000, 64, 2, 128, -2535, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
